uart_rx: RTL and testbench

- Asynchronous serial receiver that pairs with the team's UART transmitter.
- Deserialises frames in the transmitter's format:
  - start bit (0)
  - 8 data bits, LSB first
  - one parity bit
  - stop bit (1, line idle high)
- Samples each bit at mid-bit using a baud timer derived from the clock frequency.
- Presents the received byte with a one-cycle strobe plus parity/framing error flags; sits between the board RX pin and the consuming logic.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Samples mid-bit and reports the byte with a one-cycle strobe plus error flags.
module uart_rx #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       odd,
    output logic [7:0] dout,
    output logic       data_strobe,
    output logic       busy,
    output logic       parity_err,
    output logic       framing_err
);

    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int BIT_COUNT  = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_COUNT = BIT_COUNT / 2;
    localparam int TW         = (clogb2(BIT_COUNT) < 1) ? 1 : clogb2(BIT_COUNT);

    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_COUNT - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rx_m;
    logic          rx_s;
    logic [TW-1:0] timer;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          half_done;
    logic          bit_done;
    logic          timer_en;
    logic          timer_clr;
    logic          cnt_clr;
    logic          shift_en;
    logic          frame_done;

    // rx_in is asynchronous to clk; the FSM only ever looks at rx_s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer_en) begin
            timer <= timer + TW'(1);
        end
    end

    assign half_done = (timer == HALF_LAST);
    assign bit_done  = (timer == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_en   = 1'b0;
        timer_clr  = 1'b0;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    timer_clr = 1'b1;
                end
            end
            START: begin
                timer_en = 1'b1;
                if (half_done) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        timer_clr = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                timer_en = 1'b1;
                if (bit_done) begin
                    shift_en  = 1'b1;
                    timer_clr = 1'b1;
                    if (bit_cnt == 4'd8) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                timer_en = 1'b1;
                if (bit_done) begin
                    frame_done = 1'b1;
                    timer_clr  = 1'b1;
                    state_nxt  = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // a held-low line must not be mistaken for a new start bit
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[8:1]};
            end
        end
    end

    // after nine shifts shreg[7:0] holds the byte and shreg[8] the parity bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout        <= '0;
            data_strobe <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            data_strobe <= frame_done;
            if (frame_done) begin
                dout        <= shreg[7:0];
                parity_err  <= (shreg[8] != ((^shreg[7:0]) ^ odd));
                framing_err <= !rx_s;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: expected frames are queued as they are sent
// and compared against the frames the receiver strobes out.
module tb_uart_rx;

    localparam int CLK_FREQUENCY = 160;
    localparam int BAUD_RATE     = 10;
    localparam int BIT_COUNT     = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       odd;
    logic [7:0] dout;
    logic       data_strobe;
    logic       busy;
    logic       parity_err;
    logic       framing_err;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } result_t;

    result_t    expQ[$];
    result_t    obsQ[$];
    int         obsCycle[$];
    int         cycle = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] lastDout = 8'h00;

    uart_rx #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .BAUD_RATE    (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .odd        (odd),
        .dout       (dout),
        .data_strobe(data_strobe),
        .busy       (busy),
        .parity_err (parity_err),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // collect every strobed frame together with the cycle it appeared in
    always @(negedge clk) begin
        if (data_strobe === 1'b1) begin
            obsQ.push_back({dout, parity_err, framing_err});
            obsCycle.push_back(cycle);
        end
    end

    task automatic clearQueues();
        expQ.delete();
        obsQ.delete();
        obsCycle.delete();
    endtask

    task automatic driveBit(input logic b);
        rx_in = b;
        repeat (BIT_COUNT) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic p, input logic s);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(d[i]);
        driveBit(p);
        driveBit(s);
    endtask

    task automatic expectFrame(input logic [7:0] d, input logic p, input logic s);
        expQ.push_back({d, (p != ((^d) ^ odd)), !s});
        lastDout = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_in = 1'b1;
        odd   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got=%h want=00", dout); end
        checks++; if (data_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe got=%b want=0", data_strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr got=%b want=0", parity_err); end
        checks++; if (framing_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr got=%b want=0", framing_err); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0 || obsQ.size() != 0) begin errors++; $display("[TB] FAIL idle_after_reset busy=%b strobes=%0d want busy=0 strobes=0", busy, obsQ.size()); end
    endtask

    task automatic test_even_parity();
        result_t e, g;
        clearQueues();
        odd = 1'b0;
        expectFrame(8'hA5, 1'b0, 1'b1);
        sendFrame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (obsQ.size() != 1) begin
            errors++; $display("[TB] FAIL even_count got=%0d want=1", obsQ.size());
        end else begin
            e = expQ.pop_front(); g = obsQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL even_frame got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL even_busy got=%b want=0", busy); end
    endtask

    task automatic test_odd_parity();
        result_t e, g;
        clearQueues();
        odd = 1'b1;
        expectFrame(8'h01, 1'b0, 1'b1);
        sendFrame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        expectFrame(8'h01, 1'b1, 1'b1);
        sendFrame(8'h01, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (obsQ.size() != 2) begin
            errors++; $display("[TB] FAIL odd_count got=%0d want=2", obsQ.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = expQ.pop_front(); g = obsQ.pop_front();
                checks++; if (g !== e) begin errors++; $display("[TB] FAIL odd_frame%0d got=%h/%b/%b want=%h/%b/%b", i, g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
            end
        end
    endtask

    task automatic test_framing();
        result_t e, g;
        clearQueues();
        odd = 1'b0;
        expectFrame(8'h3C, 1'b0, 1'b0);
        sendFrame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL framing_busy_low_line got=%b want=1", busy); end
        checks++;
        if (obsQ.size() != 1) begin
            errors++; $display("[TB] FAIL framing_count got=%0d want=1", obsQ.size());
        end else begin
            e = expQ.pop_front(); g = obsQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL framing_frame got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
        end
        rx_in = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL framing_busy_release got=%b want=0", busy); end
        checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL framing_extra_strobe got=%0d want=0", obsQ.size()); end
    endtask

    task automatic test_glitch();
        logic sawBusy;
        clearQueues();
        sawBusy = 1'b0;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) sawBusy = 1'b1;
        end
        checks++; if (sawBusy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_pulse got=%b want=1", sawBusy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end got=%b want=0", busy); end
        checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL glitch_strobe got=%0d want=0", obsQ.size()); end
        checks++; if (dout !== lastDout) begin errors++; $display("[TB] FAIL glitch_dout got=%h want=%h", dout, lastDout); end
    endtask

    task automatic test_back_to_back();
        result_t e, g;
        clearQueues();
        odd = 1'b0;
        expectFrame(8'h55, 1'b0, 1'b1);
        sendFrame(8'h55, 1'b0, 1'b1);
        expectFrame(8'hFF, 1'b0, 1'b1);
        sendFrame(8'hFF, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (obsQ.size() != 2) begin
            errors++; $display("[TB] FAIL b2b_count got=%0d want=2", obsQ.size());
        end else begin
            checks++; if (obsCycle[1] - obsCycle[0] != 11 * BIT_COUNT) begin errors++; $display("[TB] FAIL b2b_spacing got=%0d want=%0d", obsCycle[1] - obsCycle[0], 11 * BIT_COUNT); end
            for (int i = 0; i < 2; i++) begin
                e = expQ.pop_front(); g = obsQ.pop_front();
                checks++; if (g !== e) begin errors++; $display("[TB] FAIL b2b_frame%0d got=%h/%b/%b want=%h/%b/%b", i, g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        result_t e, g;
        logic [7:0] partial;
        clearQueues();
        odd = 1'b0;
        partial = 8'h9A;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(partial[i]);
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL midreset_dout got=%h want=00", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%b want=0", busy); end
        checks++; if ({data_strobe, parity_err, framing_err} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_flags got=%b want=000", {data_strobe, parity_err, framing_err}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (obsQ.size() != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_strobe strobes=%0d busy=%b want 0/0", obsQ.size(), busy); end
        expectFrame(8'h12, 1'b0, 1'b1);
        sendFrame(8'h12, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (obsQ.size() != 1) begin
            errors++; $display("[TB] FAIL midreset_next_count got=%0d want=1", obsQ.size());
        end else begin
            e = expQ.pop_front(); g = obsQ.pop_front();
            checks++; if (g !== e) begin errors++; $display("[TB] FAIL midreset_next_frame got=%h/%b/%b want=%h/%b/%b", g.data, g.perr, g.ferr, e.data, e.perr, e.ferr); end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
